// File: rtl/div_sequencer.sv
// Iterative restoring divider for RV32IM DIV/DIVU/REM/REMU in the EX stage.
// Stalls the pipeline while busy and strobes DONE for one cycle with the result.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      OP,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_op_rem;
  logic                  r_neg_q, r_neg_r;
  logic [XLEN-1:0]       r_quo, r_div, r_rem, r_result;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy, r_done;

  logic                  w_signed, w_sign_a, w_sign_b, w_div0, w_ovf, w_fast, w_issue;
  logic [XLEN:0]         w_shift;
  logic                  w_ge;
  logic [XLEN-1:0]       w_sub, w_quo_fix, w_rem_fix, w_fast_res;

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] f_abs(input logic signed [XLEN-1:0] v, input logic en);
    return (en && (v < 0)) ? f_neg(v) : v;
  endfunction

  assign w_signed   = ~OP[0];
  assign w_sign_a   = w_signed & OPERAND_A[XLEN-1];
  assign w_sign_b   = w_signed & OPERAND_B[XLEN-1];
  assign w_div0     = (OPERAND_B == '0);
  assign w_ovf      = w_signed && (OPERAND_A == MIN_NEG) && (OPERAND_B == '1);
  assign w_fast     = w_div0 | w_ovf;
  assign w_issue    = (r_state == S_IDLE) & START & ~FLUSH;
  assign w_fast_res = w_div0 ? (OP[1] ? OPERAND_A : '1) : (OP[1] ? '0 : MIN_NEG);

  // The wide compare covers the bit shifted out of the remainder; the
  // difference itself always fits in XLEN bits when the compare succeeds.
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_sub      = w_shift[XLEN-1:0] - r_div;
  assign w_quo_fix  = r_neg_q ? f_neg(r_quo) : r_quo;
  assign w_rem_fix  = r_neg_r ? f_neg(r_rem) : r_rem;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CW'(XLEN-1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (FLUSH) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_op_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_quo    <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!FLUSH) begin
      case (r_state)
        S_IDLE: if (START) begin
          r_op_rem <= OP[1];
          r_neg_q  <= w_sign_a ^ w_sign_b;
          r_neg_r  <= w_sign_a;
          r_quo    <= f_abs(OPERAND_A, w_signed);
          r_div    <= f_abs(OPERAND_B, w_signed);
          r_rem    <= '0;
          r_cnt    <= '0;
          if (w_fast) r_result <= w_fast_res;
        end
        S_CALC: begin
          r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX:   r_result <= r_op_rem ? w_rem_fix : w_quo_fix;
        default: ;
      endcase
    end
  end

  assign STALL  = w_issue | (r_state == S_CALC) | (r_state == S_FIX);
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign RESULT = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized ops
// compared against an arithmetic reference of the RV32M divide rules.
module tb_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [31:0] OPERAND_A = '0;
  logic [31:0] OPERAND_B = '0;
  logic        FLUSH = 1'b0;
  logic        STALL, BUSY, DONE;
  logic [31:0] RESULT;

  int n_chk = 0;
  int n_fail = 0;

  div_sequencer #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .FLUSH(FLUSH),
    .STALL(STALL), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stalls(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int stalls, cyc, extra;
    bit seen;
    logic [31:0] res;
    @(posedge CLK); #1;
    START = 1'b1; OP = op; OPERAND_A = a; OPERAND_B = b;
    stalls = 0; cyc = 0; seen = 1'b0; res = '0;
    while (!seen && cyc < 100) begin
      @(negedge CLK);
      if (STALL) stalls++;
      if (DONE) begin
        seen = 1'b1;
        res  = RESULT;
      end else begin
        @(posedge CLK); #1;
        OPERAND_A = $urandom; OPERAND_B = $urandom; OP = 2'($urandom);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_stall_cycles"}, stalls, ref_stalls(op, a, b));
    check({tag, "_result"}, res, ref_result(op, a, b));
    // START stays high across the DONE->IDLE edge, then drops
    @(posedge CLK); #1;
    START = 1'b0;
    extra = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE || BUSY) extra++;
    end
    check({tag, "_no_restart"}, extra, 0);
    check({tag, "_result_held"}, RESULT, ref_result(op, a, b));
  endtask

  initial begin
    logic [31:0] prev, ra, rb;
    logic [1:0]  rop;
    int dn;

    #12;
    check("reset_busy", 32'(BUSY), 0);
    check("reset_done", 32'(DONE), 0);
    check("reset_stall", 32'(STALL), 0);
    check("reset_result", RESULT, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    do_op("div_100_7", 2'b00, 32'd100, 32'd7);
    do_op("rem_100_7", 2'b10, 32'd100, 32'd7);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2);
    do_op("div_by0", 2'b00, 32'd5, 32'd0);
    do_op("remu_by0", 2'b11, 32'd5, 32'd0);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // FLUSH during CALC cycle 10
    do_op("pre_flush", 2'b01, 32'd1000, 32'd3);
    prev = RESULT;
    @(posedge CLK); #1;
    START = 1'b1; OP = 2'b00; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
    repeat (10) @(posedge CLK);
    #1;
    FLUSH = 1'b1; START = 1'b0;
    @(negedge CLK);
    check("flush_busy_before", 32'(BUSY), 1);
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    check("flush_busy_after", 32'(BUSY), 0);
    check("flush_stall_after", 32'(STALL), 0);
    check("flush_result_kept", RESULT, prev);
    dn = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    check("flush_no_done", dn, 0);
    do_op("divu_after_flush", 2'b01, 32'hFFFF_FFFF, 32'd16);

    // FLUSH and START together in IDLE
    @(posedge CLK); #1;
    START = 1'b1; FLUSH = 1'b1; OP = 2'b00; OPERAND_A = 32'd9; OPERAND_B = 32'd2;
    @(negedge CLK);
    check("flush_start_stall", 32'(STALL), 0);
    @(posedge CLK); #1;
    START = 1'b0; FLUSH = 1'b0;
    @(negedge CLK);
    check("flush_start_busy", 32'(BUSY), 0);

    // RESET during FIX
    @(posedge CLK); #1;
    START = 1'b1; OP = 2'b00; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
    repeat (33) @(posedge CLK);
    @(negedge CLK);
    check("fix_busy", 32'(BUSY), 1);
    check("fix_stall", 32'(STALL), 1);
    RESET = 1'b1;
    #1;
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_result", RESULT, 0);
    @(posedge CLK); #1;
    RESET = 1'b0; START = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) dn++;
    end
    check("rst_no_done", dn, 0);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
